// File: rtl/aftab_csr_trap_sequencer.sv
// AFTAB CSR trap/MRET sequencer: drives the interrupt register bank
// through the mstatus/mepc/mcause/mtval/mtvec accesses of trap entry and MRET.
module aftab_csr_trap_sequencer #(
   parameter int len = 32
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           trapReq,
   input  logic           mretReq,
   input  logic [len-1:0] pcIn,
   input  logic [len-1:0] causeIn,
   input  logic [len-1:0] tvalIn,
   input  logic [len-1:0] outRegBank,
   output logic           writeRegBank,
   output logic [11:0]    addressRegBank,
   output logic [len-1:0] inputRegBank,
   output logic           busy,
   output logic           done,
   output logic [len-1:0] targetPC
);

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_T_RD_MST = 4'd1,
      S_T_WR_MST = 4'd2,
      S_T_WR_EPC = 4'd3,
      S_T_WR_CAU = 4'd4,
      S_T_WR_TVL = 4'd5,
      S_T_RD_VEC = 4'd6,
      S_R_RD_MST = 4'd7,
      S_R_WR_MST = 4'd8,
      S_R_RD_EPC = 4'd9,
      S_DONE     = 4'd10
   } state_t;

   localparam logic [11:0] A_MSTATUS = 12'h300;
   localparam logic [11:0] A_MTVEC   = 12'h305;
   localparam logic [11:0] A_MEPC    = 12'h341;
   localparam logic [11:0] A_MCAUSE  = 12'h342;
   localparam logic [11:0] A_MTVAL   = 12'h343;

   state_t         state_q, state_d;
   logic           wr_q, wr_d;
   logic [11:0]    addr_q, addr_d;
   logic [len-1:0] data_q, data_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic [len-1:0] tpc_q, tpc_d;
   logic [len-1:0] pc_q, pc_d;
   logic [len-1:0] cause_q, cause_d;
   logic [len-1:0] tval_q, tval_d;
   logic [len-1:0] mst_q, mst_d;
   logic [len-1:0] mst_trap, mst_ret;
   logic [len-1:0] vec_base, vec_off;

   // Next state plus the bank-side outputs that belong to that next state,
   // so every output leaves a flop and is stable for the whole state.
   always_comb begin
      state_d  = S_IDLE;
      wr_d     = 1'b0;
      addr_d   = 12'h000;
      data_d   = '0;
      done_d   = 1'b0;
      pc_d     = pc_q;
      cause_d  = cause_q;
      tval_d   = tval_q;
      mst_d    = mst_q;
      tpc_d    = tpc_q;

      mst_trap        = outRegBank;
      mst_trap[7]     = outRegBank[3];
      mst_trap[3]     = 1'b0;
      mst_trap[12:11] = 2'b11;

      mst_ret         = outRegBank;
      mst_ret[3]      = outRegBank[7];
      mst_ret[7]      = 1'b1;
      mst_ret[12:11]  = 2'b11;

      vec_base = {outRegBank[len-1:2], 2'b00};
      vec_off  = {cause_q[len-3:0], 2'b00};

      case (state_q)
         S_IDLE: begin
            if (trapReq) begin
               state_d = S_T_RD_MST;
               addr_d  = A_MSTATUS;
               pc_d    = pcIn;
               cause_d = causeIn;
               tval_d  = tvalIn;
            end else if (mretReq) begin
               state_d = S_R_RD_MST;
               addr_d  = A_MSTATUS;
            end
         end
         S_T_RD_MST: begin
            mst_d   = outRegBank;
            state_d = S_T_WR_MST;
            wr_d    = 1'b1;
            addr_d  = A_MSTATUS;
            data_d  = mst_trap;
         end
         S_T_WR_MST: begin
            state_d = S_T_WR_EPC;
            wr_d    = 1'b1;
            addr_d  = A_MEPC;
            data_d  = pc_q & ~len'(3);
         end
         S_T_WR_EPC: begin
            state_d = S_T_WR_CAU;
            wr_d    = 1'b1;
            addr_d  = A_MCAUSE;
            data_d  = cause_q;
         end
         S_T_WR_CAU: begin
            state_d = S_T_WR_TVL;
            wr_d    = 1'b1;
            addr_d  = A_MTVAL;
            data_d  = tval_q;
         end
         S_T_WR_TVL: begin
            state_d = S_T_RD_VEC;
            addr_d  = A_MTVEC;
         end
         S_T_RD_VEC: begin
            state_d = S_DONE;
            done_d  = 1'b1;
            if (outRegBank[1:0] == 2'b01 && cause_q[len-1])
               tpc_d = vec_base + vec_off;
            else
               tpc_d = vec_base;
         end
         S_R_RD_MST: begin
            mst_d   = outRegBank;
            state_d = S_R_WR_MST;
            wr_d    = 1'b1;
            addr_d  = A_MSTATUS;
            data_d  = mst_ret;
         end
         S_R_WR_MST: begin
            state_d = S_R_RD_EPC;
            addr_d  = A_MEPC;
         end
         S_R_RD_EPC: begin
            state_d = S_DONE;
            done_d  = 1'b1;
            tpc_d   = outRegBank;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // State, registered outputs and request latches.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         wr_q    <= 1'b0;
         addr_q  <= 12'h000;
         data_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         tpc_q   <= '0;
         pc_q    <= '0;
         cause_q <= '0;
         tval_q  <= '0;
         mst_q   <= '0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         tpc_q   <= tpc_d;
         pc_q    <= pc_d;
         cause_q <= cause_d;
         tval_q  <= tval_d;
         mst_q   <= mst_d;
      end
   end

   assign writeRegBank   = wr_q;
   assign addressRegBank = addr_q;
   assign inputRegBank   = data_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign targetPC       = tpc_q;

endmodule

// File: tb/tb_aftab_csr_trap_sequencer.sv
// Bench for aftab_csr_trap_sequencer: vector table of trap/MRET sequences
// against a simple bank read model, plus reset, collision, hold and abort cases.
module tb_aftab_csr_trap_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        trapReq, mretReq;
   logic [31:0] pcIn, causeIn, tvalIn;
   logic [31:0] outRegBank;
   logic        writeRegBank;
   logic [11:0] addressRegBank;
   logic [31:0] inputRegBank;
   logic        busy, done;
   logic [31:0] targetPC;

   logic [31:0] bk_mst, bk_vec, bk_epc;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   aftab_csr_trap_sequencer #(.len(32)) dut (
      .clk(clk),
      .rst(rst),
      .trapReq(trapReq),
      .mretReq(mretReq),
      .pcIn(pcIn),
      .causeIn(causeIn),
      .tvalIn(tvalIn),
      .outRegBank(outRegBank),
      .writeRegBank(writeRegBank),
      .addressRegBank(addressRegBank),
      .inputRegBank(inputRegBank),
      .busy(busy),
      .done(done),
      .targetPC(targetPC)
   );

   // Bank read port model: combinational from the address.
   always_comb begin
      case (addressRegBank)
         12'h300: outRegBank = bk_mst;
         12'h305: outRegBank = bk_vec;
         12'h341: outRegBank = bk_epc;
         default: outRegBank = 32'hBAD0_0000;
      endcase
   end

   typedef struct {
      bit          is_mret;
      logic [31:0] mst, vec, epc;
      logic [31:0] pc, cause, tval;
      logic [31:0] exp_mst, exp_epc, exp_tpc;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic wait_idle();
      bit ok = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (!busy) begin
            ok = 1;
            break;
         end
      end
      if (!ok) chk("idle_timeout", 64'd1, 64'd0);
   endtask

   task automatic run_vec(input int i);
      vec_t        v;
      int          n;
      logic [14:0] ctl[1:7];
      logic [31:0] dat[1:7];
      v = tbl[i];
      bk_mst = v.mst;
      bk_vec = v.vec;
      bk_epc = v.epc;
      for (int c = 1; c <= 7; c++) begin
         ctl[c] = '0;
         dat[c] = '0;
      end
      if (!v.is_mret) begin
         n = 7;
         ctl[1] = {3'b100, 12'h300};
         ctl[2] = {3'b101, 12'h300}; dat[2] = v.exp_mst;
         ctl[3] = {3'b101, 12'h341}; dat[3] = v.exp_epc;
         ctl[4] = {3'b101, 12'h342}; dat[4] = v.cause;
         ctl[5] = {3'b101, 12'h343}; dat[5] = v.tval;
         ctl[6] = {3'b100, 12'h305};
         ctl[7] = {3'b110, 12'h000};
      end else begin
         n = 4;
         ctl[1] = {3'b100, 12'h300};
         ctl[2] = {3'b101, 12'h300}; dat[2] = v.exp_mst;
         ctl[3] = {3'b100, 12'h341};
         ctl[4] = {3'b110, 12'h000};
      end
      @(negedge clk);
      pcIn    = v.pc;
      causeIn = v.cause;
      tvalIn  = v.tval;
      trapReq = !v.is_mret;
      mretReq = v.is_mret;
      @(posedge clk);
      for (int c = 1; c <= n; c++) begin
         @(negedge clk);
         if (c == 1) begin
            trapReq = 1'b0;
            mretReq = 1'b0;
         end
         chk($sformatf("v%0d_c%0d_ctl", i, c),
             {49'd0, busy, done, writeRegBank, addressRegBank},
             {49'd0, ctl[c]});
         chk($sformatf("v%0d_c%0d_data", i, c),
             {32'd0, inputRegBank}, {32'd0, dat[c]});
      end
      chk($sformatf("v%0d_tpc", i), {32'd0, targetPC}, {32'd0, v.exp_tpc});
      @(negedge clk);
      chk($sformatf("v%0d_idle", i),
          {49'd0, busy, done, writeRegBank, addressRegBank}, 64'd0);
      chk($sformatf("v%0d_tpc_hold", i), {32'd0, targetPC},
          {32'd0, v.exp_tpc});
   endtask

   initial begin
      logic [47:0] log_addr;
      int          nw;

      tbl[0] = '{0, 32'h0000_0008, 32'h0000_1000, 32'h0,
                 32'h0000_0204, 32'h0000_0002, 32'hDEAD_BEEF,
                 32'h0000_1880, 32'h0000_0204, 32'h0000_1000};
      tbl[1] = '{0, 32'h0000_0000, 32'h0000_2001, 32'h0,
                 32'h0000_1003, 32'h8000_0007, 32'h0000_0000,
                 32'h0000_1800, 32'h0000_1000, 32'h0000_201C};
      tbl[2] = '{0, 32'hFFFF_FFFF, 32'h0000_2001, 32'h0,
                 32'h0000_0100, 32'h0000_0007, 32'h1234_5678,
                 32'hFFFF_FFF7, 32'h0000_0100, 32'h0000_2000};
      tbl[3] = '{0, 32'h0000_0000, 32'hFFFF_FFF1, 32'h0,
                 32'h0000_0010, 32'h8000_0004, 32'h0000_0001,
                 32'h0000_1800, 32'h0000_0010, 32'h0000_0000};
      tbl[4] = '{0, 32'h0000_0008, 32'h0000_3003, 32'h0,
                 32'h0000_0020, 32'h8000_0001, 32'h0000_0002,
                 32'h0000_1880, 32'h0000_0020, 32'h0000_3000};
      tbl[5] = '{1, 32'h0000_1880, 32'h0, 32'h0000_0208,
                 32'h0, 32'h0, 32'h0,
                 32'h0000_1888, 32'h0, 32'h0000_0208};
      tbl[6] = '{1, 32'h0000_0000, 32'h0, 32'hCAFE_0000,
                 32'h0, 32'h0, 32'h0,
                 32'h0000_1880, 32'h0, 32'hCAFE_0000};
      tbl[7] = '{1, 32'hFFFF_FF7F, 32'h0, 32'h0000_0400,
                 32'h0, 32'h0, 32'h0,
                 32'hFFFF_FFF7, 32'h0, 32'h0000_0400};

      // Reset with a pending trap request.
      rst     = 1'b0;
      trapReq = 1'b1;
      mretReq = 1'b0;
      pcIn    = 32'h0000_0100;
      causeIn = 32'h0000_0003;
      tvalIn  = 32'h0;
      bk_mst  = 32'h0;
      bk_vec  = 32'h0000_0400;
      bk_epc  = 32'h0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("rst_outs_%0d", c),
             {17'd0, busy, done, writeRegBank, addressRegBank, inputRegBank},
             64'd0);
      end
      chk("rst_tpc", {32'd0, targetPC}, 64'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_accept", {49'd0, busy, writeRegBank, done, addressRegBank},
          {49'd0, 3'b100, 12'h300});
      trapReq = 1'b0;
      wait_idle();

      for (int i = 0; i < 8; i++) run_vec(i);

      // Collision, then MRET pulsed while busy.
      bk_mst = 32'h0000_0008;
      bk_vec = 32'h0000_1000;
      @(negedge clk);
      pcIn    = 32'h0000_0300;
      causeIn = 32'h0000_0005;
      tvalIn  = 32'h0;
      trapReq = 1'b1;
      mretReq = 1'b1;
      @(posedge clk);
      log_addr = '0;
      nw       = 0;
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         if (c == 1) begin
            trapReq = 1'b0;
            mretReq = 1'b0;
         end
         if (c == 3) mretReq = 1'b1;
         if (c == 4) mretReq = 1'b0;
         if (writeRegBank) begin
            log_addr = {log_addr[35:0], addressRegBank};
            nw++;
         end
      end
      chk("coll_done", {63'd0, done}, 64'd1);
      chk("coll_nwr", 64'(nw), 64'd4);
      chk("coll_seq", {16'd0, log_addr},
          {16'd0, 12'h300, 12'h341, 12'h342, 12'h343});
      @(negedge clk);
      chk("coll_idle1", {63'd0, busy}, 64'd0);
      @(negedge clk);
      chk("coll_idle2", {63'd0, busy}, 64'd0);

      // Held trap request is re-accepted right after DONE.
      @(negedge clk);
      trapReq = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         if (c == 7) chk("hold_done7", {62'd0, busy, done}, 64'd3);
         if (c == 8) chk("hold_idle8", {62'd0, busy, done}, 64'd0);
         if (c == 9)
            chk("hold_reacc9", {51'd0, busy, addressRegBank},
                {51'd0, 1'b1, 12'h300});
      end
      trapReq = 1'b0;
      wait_idle();

      // Reset during T_WR_CAU aborts the sequence.
      @(negedge clk);
      pcIn    = 32'h0000_0500;
      causeIn = 32'h0000_0002;
      tvalIn  = 32'h0000_0077;
      trapReq = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         if (c == 1) trapReq = 1'b0;
      end
      chk("abort_in_cau", {51'd0, writeRegBank, addressRegBank},
          {51'd0, 1'b1, 12'h342});
      #1 rst = 1'b0;
      #1;
      chk("abort_outs",
          {17'd0, busy, done, writeRegBank, addressRegBank, inputRegBank},
          64'd0);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk($sformatf("abort_nowr_%0d", c), {63'd0, writeRegBank}, 64'd0);
      end
      rst = 1'b1;
      @(negedge clk);
      chk("abort_idle", {62'd0, busy, writeRegBank}, 64'd0);
      @(negedge clk);
      chk("abort_idle2", {62'd0, busy, writeRegBank}, 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/aftab_csr_trap_sequencer.md
Name: aftab_csr_trap_sequencer

Overview:
- Multi-cycle FSM directly upstream of the AFTAB interrupt register bank. It is the sole driver of the bank's writeRegBank, addressRegBank and inputRegBank during trap entry and MRET.
- Trap entry: read-modify-writes mstatus, then writes mepc, mcause and mtval, reads mtvec and computes the handler PC.
- MRET: restores mstatus and returns mepc as the target PC.
- The bank read path (outRegBank) is combinational from addressRegBank, so every read costs one state.

Parameters:
- len, 32, data width of the CSR datapath and PC.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- trapReq  input  1  request trap entry; sampled only in IDLE.
- mretReq  input  1  request MRET; sampled only in IDLE.
- pcIn  input  len  PC of the trapping instruction; latched on acceptance.
- causeIn  input  len  mcause value (bit31 = interrupt); latched on acceptance.
- tvalIn  input  len  mtval value; latched on acceptance.
- outRegBank  input  len  read data from the register bank.
- writeRegBank  output  1  bank write strobe.
- addressRegBank  output  12  CSR address to the bank.
- inputRegBank  output  len  bank write data.
- busy  output  1  high whenever the state is not IDLE.
- done  output  1  one-cycle pulse; targetPC is valid in the same cycle.
- targetPC  output  len  handler PC (trap) or mepc (MRET); held until the next acceptance.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0; addressRegBank=12'h000.
  - All internal latches (pc, cause, tval, saved mstatus, targetPC) are 0.
  - Reset mid-sequence aborts the sequence; CSR writes already performed are not undone.
- IDLE:
  - writeRegBank=0, addressRegBank=0, inputRegBank=0.
  - trapReq=1 at a rising edge: latch pcIn/causeIn/tvalIn, go to T_RD_MST.
  - Otherwise mretReq=1: go to R_RD_MST.
  - trapReq and mretReq both high: trap wins and the MRET is dropped.
- Requests are ignored while busy; the requester holds them until it observes done.
- Trap states (one cycle each):
  - T_RD_MST: addr 12'h300, write=0; capture outRegBank into savedMst.
  - T_WR_MST: addr 12'h300, write=1, data = savedMst with [7]=savedMst[3], [3]=0, [12:11]=2'b11.
  - T_WR_EPC: addr 12'h341, write=1, data = {pc[31:2],2'b00}.
  - T_WR_CAU: addr 12'h342, write=1, data = cause.
  - T_WR_TVL: addr 12'h343, write=1, data = tval.
  - T_RD_VEC: addr 12'h305, write=0; base = {outRegBank[31:2],2'b00}.
    - If outRegBank[1:0]==2'b01 and cause[31]==1: targetPC = base + {cause[29:0],2'b00}, modulo 2^32.
    - Otherwise targetPC = base. Mode 2'b1x is treated as direct.
  - DONE: done=1, write=0, addr=0; next state IDLE.
- MRET states:
  - R_RD_MST: addr 12'h300, capture savedMst.
  - R_WR_MST: addr 12'h300, write=1, data = savedMst with [3]=savedMst[7], [7]=1, [12:11]=2'b11.
  - R_RD_EPC: addr 12'h341; targetPC = outRegBank.
  - DONE, then IDLE.
- Latency, with the request accepted at edge 0:
  - Trap: busy in cycles 1..7, done in cycle 7.
  - MRET: busy in cycles 1..4, done in cycle 4.
  - A new request can be accepted at the edge ending cycle 8 (trap) or cycle 5 (MRET).
- In every state, inputRegBank is 0 whenever writeRegBank=0.
- writeRegBank is never high for more than one cycle per CSR address within a sequence.
- Illegal state encodings return to IDLE on the next edge.

Test Plan:
- Reset:
  - Stimulus: assert rst=0 with trapReq=1.
  - Response: all outputs 0, no write strobes. After release with trapReq held, acceptance occurs on the first edge.
- Direct trap:
  - Stimulus: mstatus=32'h0000_0008, mtvec=32'h0000_1000, pcIn=32'h0000_0204, causeIn=32'h0000_0002, tvalIn=32'hDEAD_BEEF.
  - Response, in order:
    - write 12'h300 ← 32'h0000_1880
    - write 12'h341 ← 32'h0000_0204
    - write 12'h342 ← 32'h0000_0002
    - write 12'h343 ← 32'hDEAD_BEEF
    - done in cycle 7, targetPC=32'h0000_1000.
- Vectored interrupt:
  - Stimulus: mtvec=32'h0000_2001, causeIn=32'h8000_0007.
  - Response: targetPC=32'h0000_201C. With causeIn=32'h0000_0007 (exception): targetPC=32'h0000_2000.
- MRET:
  - Stimulus: mstatus=32'h0000_1880, mepc=32'h0000_0208, mretReq=1.
  - Response: write 12'h300 ← 32'h0000_1888; done in cycle 4 with targetPC=32'h0000_0208.
- Collision and busy:
  - Stimulus: trapReq and mretReq high together; then mretReq pulsed during busy.
  - Response: only the trap sequence runs and the pulsed MRET is ignored. Held requests are re-accepted right after DONE.
- Wrap and abort:
  - mtvec=32'hFFFF_FFF1, causeIn=32'h8000_0004: targetPC=32'h0000_0000.
  - rst=0 during T_WR_CAU: no further writes, state returns to IDLE, busy=0.
